// File: rtl/row_matmul_sequencer.sv
// row_matmul_sequencer: hands one packed row at a time to a (1,D).(D,D)
// row-by-matrix datapath. It restarts the datapath, waits for its result flag
// under a watchdog, then rescales each 2W-bit lane to W bits with saturation.
// Optional build macro: RELU_SAT_EN. When it is defined, negative lanes are
// clamped to zero after saturation.
module row_matmul_sequencer #(
    parameter int W       = 16,
    parameter int D       = 8,
    parameter int FRAC    = 12,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,          // asynchronous, active-low
    input  logic [D*W-1:0]   in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             mm_rst,
    output logic [D*W-1:0]   mm_packed_a,
    input  logic [D*2*W-1:0] mm_out_d,
    input  logic             mm_out_v,
    output logic [D*W-1:0]   out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             err_timeout
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_RUN,
        S_HOLD
    } state_t;

    state_t            state_q, state_d;
    logic [WD_W-1:0]   watchdog_q, watchdog_d;
    logic [D*W-1:0]    mm_packed_a_q, mm_packed_a_d;
    logic [D*W-1:0]    out_data_q, out_data_d;
    logic              err_timeout_q, err_timeout_d;
    logic              in_ready_q, in_ready_d;
    logic              mm_rst_q, mm_rst_d;
    logic              out_valid_q, out_valid_d;
    logic              busy_q, busy_d;
    logic [D*W-1:0]    lane_scaled;

    // Per-lane rescale: arithmetic shift (floor), then saturate to signed W.
    for (genvar gi = 0; gi < D; gi++) begin : g_lane
        localparam logic signed [2*W-1:0] MAX_V = {{(W+1){1'b0}}, {(W-1){1'b1}}};
        localparam logic signed [2*W-1:0] MIN_V = {{(W+1){1'b1}}, {(W-1){1'b0}}};
        logic signed [2*W-1:0] acc;
        logic signed [2*W-1:0] shifted;
        logic        [W-1:0]   sat;

        assign acc     = mm_out_d[gi*2*W +: 2*W];
        assign shifted = acc >>> FRAC;
        assign sat     = (shifted > MAX_V) ? {1'b0, {(W-1){1'b1}}} :
                         (shifted < MIN_V) ? {1'b1, {(W-1){1'b0}}} :
                                             shifted[W-1:0];
`ifdef RELU_SAT_EN
        assign lane_scaled[gi*W +: W] = sat[W-1] ? '0 : sat;
`else
        assign lane_scaled[gi*W +: W] = sat;
`endif
    end

    // Next-state, watchdog and datapath-register update logic.
    always_comb begin
        state_d       = state_q;
        watchdog_d    = watchdog_q;
        mm_packed_a_d = mm_packed_a_q;
        out_data_d    = out_data_q;
        err_timeout_d = err_timeout_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready_q) begin
                    mm_packed_a_d = in_data;
                    state_d       = S_START;
                end
            end
            S_START: begin
                watchdog_d = '0;
                state_d    = S_RUN;
            end
            S_RUN: begin
                watchdog_d = watchdog_q + WD_W'(1);
                // A zero count marks the first RUN cycle, where the flag may be stale.
                if (mm_out_v && (watchdog_q != '0)) begin
                    out_data_d = lane_scaled;
                    state_d    = S_HOLD;
                end else if (watchdog_d == WD_W'(TIMEOUT)) begin
                    err_timeout_d = 1'b1;
                    state_d       = S_IDLE;
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Handshake and status outputs are registered copies of the next state.
        in_ready_d  = (state_d == S_IDLE);
        mm_rst_d    = (state_d == S_START);
        out_valid_d = (state_d == S_HOLD);
        busy_d      = (state_d != S_IDLE);
    end

    // State and output registers; reset holds the datapath in restart.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            watchdog_q    <= '0;
            mm_packed_a_q <= '0;
            out_data_q    <= '0;
            err_timeout_q <= 1'b0;
            in_ready_q    <= 1'b0;
            mm_rst_q      <= 1'b1;
            out_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            watchdog_q    <= watchdog_d;
            mm_packed_a_q <= mm_packed_a_d;
            out_data_q    <= out_data_d;
            err_timeout_q <= err_timeout_d;
            in_ready_q    <= in_ready_d;
            mm_rst_q      <= mm_rst_d;
            out_valid_q   <= out_valid_d;
            busy_q        <= busy_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign mm_rst      = mm_rst_q;
    assign mm_packed_a = mm_packed_a_q;
    assign out_data    = out_data_q;
    assign out_valid   = out_valid_q;
    assign busy        = busy_q;
    assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_row_matmul_sequencer.sv
// Testbench for row_matmul_sequencer: directed rows, a datapath flag model,
// and a scoreboard whose monitor checks every output transfer.
module tb_row_matmul_sequencer;
    localparam int W = 16;
    localparam int D = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [D*W-1:0]   in_data;
    logic             in_valid;
    logic             in_ready;
    logic             mm_rst;
    logic [D*W-1:0]   mm_packed_a;
    logic [D*2*W-1:0] mm_out_d;
    logic             mm_out_v;
    logic [D*W-1:0]   out_data;
    logic             out_valid;
    logic             out_ready;
    logic             busy;
    logic             err_timeout;

    int n_checks = 0;
    int n_fail   = 0;
    int xfer_cnt = 0;
    int mm_rst_cnt = 0;
    logic [D*W-1:0] exp_q[$];

    // datapath flag model: 0 = flag after dp_dly cycles since mm_rst, 1 = always high, 2 = toggling
    int dp_mode = 0;
    int dp_dly  = 3;
    int dp_cnt  = 0;

    always #5 clk = ~clk;

    row_matmul_sequencer #(.W(W), .D(D), .FRAC(12), .TIMEOUT(64)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .mm_rst(mm_rst), .mm_packed_a(mm_packed_a), .mm_out_d(mm_out_d), .mm_out_v(mm_out_v),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .err_timeout(err_timeout)
    );

    initial mm_out_v = 1'b0;

    // Datapath model drives its flag on the falling edge, away from the DUT sampling edge.
    always @(negedge clk) begin
        if (mm_rst) begin
            dp_cnt = 0;
            mm_rst_cnt++;
        end else if (dp_cnt < 1000) begin
            dp_cnt++;
        end
        case (dp_mode)
            1:       mm_out_v = 1'b1;
            2:       mm_out_v = ~mm_out_v;
            default: mm_out_v = (!mm_rst && dp_cnt >= dp_dly);
        endcase
    end

    // Monitor: each output handshake pops and checks one expected row.
    always @(negedge clk) begin
        logic [D*W-1:0] e;
        if (rst && out_valid && out_ready) begin
            xfer_cnt++;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL out_unexpected: got out_data=%h, required no transfer", out_data);
            end else begin
                e = exp_q.pop_front();
                if (out_data !== e) begin
                    n_fail++;
                    $display("FAIL out_data: got %h, required %h", out_data, e);
                end else begin
                    $display("xfer %0d out_data=%h ok", xfer_cnt, out_data);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [D*W-1:0] act, input logic [D*W-1:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end else begin
            $display("check %s = %h ok", name, act);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_row(input logic [D*W-1:0] d, input logic [D*2*W-1:0] res);
        int n;
        mm_out_d = res;
        in_data  = d;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) begin
            n_checks++;
            n_fail++;
            $display("FAIL in_handshake: in_ready stayed 0 for %0d cycles, required 1", n);
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (!out_valid && n < 200) begin
            tick();
            n++;
        end
    endtask

    initial begin
        logic [D*W-1:0]   d, e;
        logic [D*2*W-1:0] r;
        int n, x0;
        logic ok;

        rst = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; mm_out_d = '0;
        repeat (3) tick();
        chk("reset_ctrl", 128'({in_ready, mm_rst, out_valid, busy, err_timeout}), 128'(5'b01000));
        chk("reset_data", out_data | mm_packed_a, '0);
        rst = 1'b1;
        tick(); tick();
        // T1: idle after release
        chk("idle_ctrl", 128'({in_ready, mm_rst, out_valid, busy, err_timeout}), 128'(5'b10000));

        // T2: unit row, lane i result i<<24 -> i<<12
        for (int i = 0; i < D; i++) begin
            d[i*W +: W]     = 16'h1000;
            r[i*2*W +: 2*W] = 32'(i) << 24;
            e[i*W +: W]     = 16'(i) << 12;
        end
        mm_rst_cnt = 0;
        dp_mode = 0; dp_dly = 3;
        exp_q.push_back(e);
        send_row(d, r);
        chk("packed_a", mm_packed_a, d);
        chk("busy_start", 128'({busy, in_ready}), 128'(2'b10));
        wait_out(n);
        chk("latency_dly3", 128'(n), 128'(4));
        repeat (3) tick();
        chk("hold_valid", 128'({out_valid, in_ready}), 128'(2'b10));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tick();
        chk("t2_xfer", 128'(xfer_cnt), 128'(1));
        chk("t2_mm_rst_pulses", 128'(mm_rst_cnt), 128'(1));
        chk("t2_valid_low", 128'(out_valid), 128'(0));

        // T3: saturation corners
        r = {32'hF800_0000, 32'h0800_0000, 32'h07FF_F000, 32'hFFFF_FFFF,
             32'h0000_1FFF, 32'hFFFF_F000, 32'h8000_0000, 32'h7FFF_0000};
`ifdef RELU_SAT_EN
        e = {16'h0000, 16'h7FFF, 16'h7FFF, 16'h0000, 16'h0001, 16'h0000, 16'h0000, 16'h7FFF};
`else
        e = {16'h8000, 16'h7FFF, 16'h7FFF, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h8000, 16'h7FFF};
`endif
        out_ready = 1'b1;
        exp_q.push_back(e);
        send_row(d, r);
        wait_out(n);
        tick(); tick();

        // Flag held high: first RUN cycle ignored, earliest output 3 edges after accept
        for (int i = 0; i < D; i++) begin
            r[i*2*W +: 2*W] = 32'(-(i * 4096));
`ifdef RELU_SAT_EN
            e[i*W +: W] = 16'h0000;
`else
            e[i*W +: W] = 16'(-i);
`endif
        end
        dp_mode = 1;
        exp_q.push_back(e);
        send_row(d, r);
        wait_out(n);
        chk("latency_min", 128'(n), 128'(3));
        tick(); tick();

        // Watchdog boundary: capture in the final RUN cycle wins
        dp_mode = 0; dp_dly = 64;
        r = {8{32'h0000_5000}};
        e = {8{16'h0005}};
        exp_q.push_back(e);
        send_row(d, r);
        wait_out(n);
        chk("latency_boundary", 128'(n), 128'(65));
        tick(); tick();
        chk("boundary_no_err", 128'(err_timeout), 128'(0));

        // T4: no result flag -> timeout after 64 RUN cycles
        dp_dly = 1000;
        x0 = xfer_cnt;
        send_row(d, r);
        n = 0;
        while (!in_ready && n < 200) begin
            tick();
            n++;
        end
        chk("timeout_cycles", 128'(n), 128'(65));
        chk("timeout_flags", 128'({err_timeout, out_valid, in_ready}), 128'(3'b101));
        chk("timeout_no_xfer", 128'(xfer_cnt), 128'(x0));
        dp_dly = 3;
        r = {8{32'hFFFF_E000}};
`ifdef RELU_SAT_EN
        e = {8{16'h0000}};
`else
        e = {8{16'hFFFE}};
`endif
        exp_q.push_back(e);
        send_row(d, r);
        wait_out(n);
        tick(); tick();
        chk("err_sticky", 128'(err_timeout), 128'(1));

        // T5: stalled output with toggling flag
        out_ready = 1'b0;
        dp_mode = 2;
        r = {8{32'h0123_4000}};
        e = {8{16'h1234}};
        exp_q.push_back(e);
        send_row(d, r);
        wait_out(n);
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!(out_valid && !in_ready && out_data === e)) ok = 1'b0;
        end
        chk("hold_stable", 128'(ok), 128'(1));
        x0 = xfer_cnt;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tick(); tick();
        chk("hold_single_xfer", 128'(xfer_cnt), 128'(x0 + 1));

        // T6: reset during RUN
        dp_mode = 0; dp_dly = 1000;
        send_row(d, r);
        repeat (5) tick();
        rst = 1'b0;
        #1;
        chk("midrun_reset_ctrl", 128'({in_ready, mm_rst, out_valid, busy, err_timeout}), 128'(5'b01000));
        chk("midrun_reset_data", out_data | mm_packed_a, '0);
        tick();
        rst = 1'b1;
        tick(); tick();
        dp_dly = 3;
        out_ready = 1'b1;
        r = {8{32'h0007_0000}};
        e = {8{16'h0070}};
        exp_q.push_back(e);
        send_row(d, r);
        wait_out(n);
        chk("post_reset_latency", 128'(n), 128'(4));
        tick(); tick();

        chk("scoreboard_empty", 128'(exp_q.size()), 128'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
